// File: rtl/issue_queue_pkg.sv
// Shared types and core-configuration defaults for the in-order issue queue.
package issue_queue_pkg;

  localparam int unsigned ISSUE_Q_DEPTH  = 8;
  localparam int unsigned NR_ISSUE_PORTS = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/issue_branch_gate.sv
// Marks which issue lanes fit under the in-flight control-flow limit, given the
// prefix count of control-flow entries in front of each lane.
module issue_branch_gate
  import issue_queue_pkg::*;
#(
  parameter int unsigned NR_LANES        = 2,
  parameter int unsigned MAX_INFLIGHT_BR = 1,
  parameter int unsigned BR_W            = 1
) (
  input  logic [NR_LANES-1:0] i_ctrl,
  input  logic [BR_W-1:0]     i_br_inflight,
  output logic [NR_LANES-1:0] o_lane_ok
);

  logic [31:0] w_acc;

  // Prefix sums are monotonic, so the resulting mask is always a prefix.
  always_comb begin
    w_acc     = 32'(i_br_inflight);
    o_lane_ok = '0;
    for (int k = 0; k < NR_LANES; k++) begin
      w_acc        = w_acc + 32'(i_ctrl[k]);
      o_lane_ok[k] = (w_acc <= 32'(MAX_INFLIGHT_BR));
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Multi-lane in-order issue buffer: circular storage with a registered count and
// issue throttling past unresolved control-flow instructions.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH           = ISSUE_Q_DEPTH,
  parameter int unsigned NR_ENQ_PORTS    = NR_ISSUE_PORTS,
  parameter int unsigned NR_DEQ_PORTS    = NR_ISSUE_PORTS,
  parameter int unsigned MAX_INFLIGHT_BR = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 flush_unissued_instr_i,
  input  scoreboard_entry_t [NR_ENQ_PORTS-1:0] enq_instr_i,
  input  logic [NR_ENQ_PORTS-1:0]              enq_ctrl_flow_i,
  input  logic [NR_ENQ_PORTS-1:0]              enq_valid_i,
  output logic [NR_ENQ_PORTS-1:0]              enq_ack_o,
  output scoreboard_entry_t [NR_DEQ_PORTS-1:0] issue_instr_o,
  output logic [NR_DEQ_PORTS-1:0]              issue_valid_o,
  input  logic [NR_DEQ_PORTS-1:0]              issue_ack_i,
  input  logic                                 resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o,
  output logic                                 full_o,
  output logic                                 empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned BrW  = $clog2(MAX_INFLIGHT_BR+1);

  scoreboard_entry_t r_mem [DEPTH];
  logic [DEPTH-1:0]  r_ctrl;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [CntW-1:0]   r_count;
  logic [BrW-1:0]    r_br_inflight;

  logic                    w_any_flush;
  logic [CntW-1:0]         w_free;
  logic [NR_DEQ_PORTS-1:0] w_lane_ctrl;
  logic [NR_DEQ_PORTS-1:0] w_lane_ok;
  logic [NR_DEQ_PORTS-1:0] w_issue_ack;
  logic [CntW-1:0]         w_n_enq;
  logic [CntW-1:0]         w_n_issue;
  logic [BrW-1:0]          w_n_br;
  logic                    w_resolve;

  assign w_any_flush = flush_i || flush_unissued_instr_i;
  // Free space from the registered count only: no issue_ack -> enq_ack path.
  assign w_free      = CntW'(DEPTH) - r_count;

  always_comb begin
    enq_ack_o = '0;
    for (int k = 0; k < NR_ENQ_PORTS; k++) begin
      enq_ack_o[k] = rst_ni && !w_any_flush && enq_valid_i[k] && (32'(k) < 32'(w_free));
    end
  end

  always_comb begin
    w_lane_ctrl   = '0;
    issue_instr_o = '0;
    for (int k = 0; k < NR_DEQ_PORTS; k++) begin
      issue_instr_o[k] = r_mem[r_rd_ptr + PtrW'(k)];
      w_lane_ctrl[k]   = r_ctrl[r_rd_ptr + PtrW'(k)];
    end
  end

  issue_branch_gate #(
    .NR_LANES        (NR_DEQ_PORTS),
    .MAX_INFLIGHT_BR (MAX_INFLIGHT_BR),
    .BR_W            (BrW)
  ) u_branch_gate (
    .i_ctrl        (w_lane_ctrl),
    .i_br_inflight (r_br_inflight),
    .o_lane_ok     (w_lane_ok)
  );

  always_comb begin
    issue_valid_o = '0;
    for (int k = 0; k < NR_DEQ_PORTS; k++) begin
      issue_valid_o[k] = rst_ni && !w_any_flush && w_lane_ok[k] && (32'(k) < 32'(r_count));
    end
  end

  assign w_issue_ack = issue_ack_i & issue_valid_o;
  assign w_n_enq     = CntW'(popcount(32'(enq_ack_o)));
  assign w_n_issue   = CntW'(popcount(32'(w_issue_ack)));
  assign w_n_br      = BrW'(popcount(32'(w_issue_ack & w_lane_ctrl)));
  // A resolve with nothing in flight is dropped so the counter cannot underflow.
  assign w_resolve   = resolve_branch_i && (r_br_inflight != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_br_inflight <= '0;
    end else if (w_any_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      if (flush_i) begin
        r_br_inflight <= '0;
      end else begin
        r_br_inflight <= r_br_inflight - BrW'(w_resolve);
      end
    end else begin
      r_rd_ptr      <= r_rd_ptr + PtrW'(w_n_issue);
      r_wr_ptr      <= r_wr_ptr + PtrW'(w_n_enq);
      r_count       <= r_count + w_n_enq - w_n_issue;
      r_br_inflight <= r_br_inflight + w_n_br - BrW'(w_resolve);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_ENQ_PORTS; k++) begin
      if (enq_ack_o[k]) begin
        r_mem[r_wr_ptr + PtrW'(k)]  <= enq_instr_i[k];
        r_ctrl[r_wr_ptr + PtrW'(k)] <= enq_ctrl_flow_i[k];
      end
    end
  end

  assign count_o = r_count;
  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ((enq_valid_i & (enq_valid_i + NR_ENQ_PORTS'(1))) == '0);
      assert ((issue_ack_i & (issue_ack_i + NR_DEQ_PORTS'(1))) == '0);
      assert ((issue_ack_i & ~issue_valid_o) == '0);
      assert (32'(r_count) <= 32'(DEPTH));
      assert (!(resolve_branch_i && !flush_i && r_br_inflight == '0));
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: queue-based reference model drives expectations,
// a separate monitor checks issued payload order on every handshake.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NENQ  = 2;
  localparam int unsigned NDEQ  = 2;
  localparam int unsigned MAXBR = 1;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic                         flush_i;
  logic                         flush_unissued_instr_i;
  scoreboard_entry_t [NENQ-1:0] enq_instr_i;
  logic [NENQ-1:0]              enq_ctrl_flow_i;
  logic [NENQ-1:0]              enq_valid_i;
  logic [NENQ-1:0]              enq_ack_o;
  scoreboard_entry_t [NDEQ-1:0] issue_instr_o;
  logic [NDEQ-1:0]              issue_valid_o;
  logic [NDEQ-1:0]              issue_ack_i;
  logic                         resolve_branch_i;
  logic [3:0]                   count_o;
  logic                         full_o;
  logic                         empty_o;

  always #5 clk_i = ~clk_i;

  issue_queue #(
    .DEPTH           (DEPTH),
    .NR_ENQ_PORTS    (NENQ),
    .NR_DEQ_PORTS    (NDEQ),
    .MAX_INFLIGHT_BR (MAXBR)
  ) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .flush_i                (flush_i),
    .flush_unissued_instr_i (flush_unissued_instr_i),
    .enq_instr_i            (enq_instr_i),
    .enq_ctrl_flow_i        (enq_ctrl_flow_i),
    .enq_valid_i            (enq_valid_i),
    .enq_ack_o              (enq_ack_o),
    .issue_instr_o          (issue_instr_o),
    .issue_valid_o          (issue_valid_o),
    .issue_ack_i            (issue_ack_i),
    .resolve_branch_i       (resolve_branch_i),
    .count_o                (count_o),
    .full_o                 (full_o),
    .empty_o                (empty_o)
  );

  typedef struct {
    scoreboard_entry_t instr;
    logic              ctrl;
  } mentry_t;

  mentry_t           m_q[$];     // reference queue contents
  scoreboard_entry_t q_exp[$];   // expected issue order
  int unsigned       m_br;       // issued-but-unresolved ctrl-flow count
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       pc_ctr = 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pmask(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Called at a falling edge; applies one cycle of stimulus, checks, advances model.
  task automatic step(input int n_enq, input logic [NENQ-1:0] ctrl, input int n_ack,
                      input bit res, input bit fl, input bit flu);
    int          free;
    int          n_acc;
    int          n_val;
    int          acc;
    int unsigned br_old;
    for (int k = 0; k < NENQ; k++) begin
      enq_instr_i[k].pc = pc_ctr + 32'(k);
      enq_instr_i[k].op = 8'($urandom);
      enq_instr_i[k].rd = 5'($urandom);
    end
    pc_ctr                 = pc_ctr + 32'(NENQ);
    enq_valid_i            = NENQ'(pmask(n_enq));
    enq_ctrl_flow_i        = ctrl;
    flush_i                = fl;
    flush_unissued_instr_i = flu;
    resolve_branch_i       = res;

    free  = DEPTH - m_q.size();
    n_acc = (fl || flu) ? 0 : ((n_enq < free) ? n_enq : free);
    n_val = 0;
    if (!fl && !flu) begin
      acc = int'(m_br);
      for (int k = 0; k < NDEQ && k < m_q.size(); k++) begin
        acc = acc + int'(m_q[k].ctrl);
        if (acc > int'(MAXBR)) break;
        n_val++;
      end
    end
    if (n_ack > n_val) n_ack = n_val;
    issue_ack_i = NDEQ'(pmask(n_ack));

    #1;
    chk("enq_ack", 64'(enq_ack_o), 64'(pmask(n_acc)));
    chk("issue_valid", 64'(issue_valid_o), 64'(pmask(n_val)));
    chk("count", 64'(count_o), 64'(m_q.size()));
    chk("full", 64'(full_o), 64'(m_q.size() == DEPTH));
    chk("empty", 64'(empty_o), 64'(m_q.size() == 0));

    br_old = m_br;
    if (fl) begin
      m_q.delete();
      q_exp.delete();
      m_br = 0;
    end else if (flu) begin
      m_q.delete();
      q_exp.delete();
      if (res && br_old > 0) m_br--;
    end else begin
      for (int k = 0; k < n_ack; k++) begin
        if (m_q[0].ctrl) m_br++;
        void'(m_q.pop_front());
      end
      if (res && br_old > 0) m_br--;
      for (int k = 0; k < n_acc; k++) begin
        m_q.push_back('{instr: enq_instr_i[k], ctrl: ctrl[k]});
        q_exp.push_back(enq_instr_i[k]);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni                 = 1'b0;
    enq_valid_i            = '1;
    enq_ctrl_flow_i        = '0;
    issue_ack_i            = '0;
    flush_i                = 1'b0;
    flush_unissued_instr_i = 1'b0;
    resolve_branch_i       = 1'b0;
    #1;
    chk("rst_enq_ack", 64'(enq_ack_o), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    enq_valid_i = '0;
    m_q.delete();
    q_exp.delete();
    m_br = 0;
    #1;
    chk("post_rst_count", 64'(count_o), 64'd0);
    chk("post_rst_empty", 64'(empty_o), 64'd1);
    chk("post_rst_full", 64'(full_o), 64'd0);
    chk("post_rst_issue_valid", 64'(issue_valid_o), 64'd0);
    @(negedge clk_i);
  endtask

  scoreboard_entry_t mon_e;

  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      for (int k = 0; k < NDEQ; k++) begin
        if (issue_valid_o[k] && issue_ack_i[k]) begin
          if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_instr lane %0d actual=%0h required=none", k, issue_instr_o[k]);
          end else begin
            mon_e = q_exp.pop_front();
            chk("issue_instr", 64'(issue_instr_o[k]), 64'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    rst_ni                 = 1'b0;
    flush_i                = 1'b0;
    flush_unissued_instr_i = 1'b0;
    resolve_branch_i       = 1'b0;
    enq_valid_i            = '0;
    enq_ctrl_flow_i        = '0;
    enq_instr_i            = '0;
    issue_ack_i            = '0;
    m_br                   = 0;
    @(negedge clk_i);
    do_reset();

    // Two ALU instrs in, visible next cycle, then drained.
    step(2, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 2, 0, 0, 0);

    // Fill to full, then ack while full: enqueue refused until next cycle.
    for (int i = 0; i < 4; i++) step(2, 2'b00, 0, 0, 0, 0);
    step(2, 2'b00, 0, 0, 0, 0);
    step(2, 2'b00, 2, 0, 0, 0);
    step(2, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b00, 2, 0, 0, 0);

    // [BR, ALU, BR]: first pair issues, second BR waits for resolve.
    step(2, 2'b01, 0, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 2, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    step(0, 2'b00, 0, 1, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);

    // Five entries with one branch in flight: partial flush keeps tracking, full flush clears.
    step(2, 2'b00, 0, 0, 0, 0);
    step(2, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b00, 2, 0, 0, 1);
    step(2, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    step(1, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    step(0, 2'b00, 0, 1, 0, 0);

    // Reset with four entries queued.
    step(2, 2'b00, 0, 0, 0, 0);
    step(2, 2'b00, 0, 0, 0, 0);
    do_reset();

    // Randomised traffic with pointer wrap, occasional flushes and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      int  r;
      bit  res;
      logic [NENQ-1:0] c;
      if (i == 1500) do_reset();
      r   = int'($urandom_range(0, 99));
      res = (m_br > 0) && ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NENQ; k++) c[k] = ($urandom_range(0, 3) == 0);
      step(int'($urandom_range(0, NENQ)), c, int'($urandom_range(0, NDEQ)), res,
           r == 0, r == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
